// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the registered control decode stage.
package ctrl_pkg;

    // Opcode encodings (decode uses opcode[3:0]).
    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_ANDI = 4'b0001;
    localparam logic [3:0] OP_ORI  = 4'b0010;
    localparam logic [3:0] OP_BGT  = 4'b0100;
    localparam logic [3:0] OP_BLT  = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_LBU  = 4'b1010;
    localparam logic [3:0] OP_SB   = 4'b1011;
    localparam logic [3:0] OP_LW   = 4'b1100;
    localparam logic [3:0] OP_SW   = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // ALU operation select.
    localparam logic [1:0] ALU_OP_A   = 2'b00;
    localparam logic [1:0] ALU_OP_AND = 2'b01;
    localparam logic [1:0] ALU_OP_OR  = 2'b10;
    localparam logic [1:0] ALU_OP_ADD = 2'b11;

    // Branch comparison select.
    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_GT = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;

    // Control bundle; first field is the MSB of the packed vector.
    typedef struct packed {
        logic       reg_write;
        logic       r15_write;
        logic [1:0] alu_op;
        logic       alu_src1;
        logic       alu_src2;
        logic       ext_src;
        logic       mem_read;
        logic       mem_to_reg;
        logic       load_byte;
        logic       mem_write;
        logic       s_byte;
        logic       branch;
        logic [1:0] branch_code;
        logic       jump;
        logic       shift_src;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ID -> EX control interface: ID-side inputs and registered EX-side outputs.
interface ctrl_pipe_unit_if #(
    parameter int unsigned OPW    = 4,
    parameter int unsigned BCNT_W = 16
);
    import ctrl_pkg::*;

    logic              id_valid;
    logic [OPW-1:0]    id_opcode;
    logic              stall;
    logic              flush;
    logic              ex_valid;
    ctrl_t             ex_ctrl;
    logic              pc_hold;
    logic              halted;
    logic              illegal;
    logic [BCNT_W-1:0] bubble_cnt;

    // Pipeline / hazard-unit side.
    modport master (
        output id_valid, id_opcode, stall, flush,
        input  ex_valid, ex_ctrl, pc_hold, halted, illegal, bubble_cnt
    );

    // Control unit side.
    modport slave (
        input  id_valid, id_opcode, stall, flush,
        output ex_valid, ex_ctrl, pc_hold, halted, illegal, bubble_cnt
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle, illegal and HALT flags.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl,
    output logic           is_illegal,
    output logic           is_halt
);

    logic [3:0] op4;
    logic       upper_nz;

    assign op4      = opcode[3:0];
    // Any set bit above the 4-bit decode field makes the opcode illegal.
    assign upper_nz = (opcode >> 4) != '0;

    // Decode table; unlisted fields and don't-cares stay 0.
    always_comb begin
        ctrl       = '0;
        is_illegal = 1'b0;
        case (op4)
            OP_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.r15_write = 1'b1;
                ctrl.alu_op    = ALU_OP_A;
            end
            OP_ANDI, OP_ORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = (op4 == OP_ANDI) ? ALU_OP_AND : ALU_OP_OR;
                ctrl.alu_src1  = 1'b1;
                ctrl.alu_src2  = 1'b1;
                ctrl.ext_src   = 1'b1;
            end
            OP_LBU, OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.alu_src1   = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.load_byte  = (op4 == OP_LBU);
            end
            OP_SB, OP_SW: begin
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.alu_src1  = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.s_byte    = (op4 == OP_SB);
            end
            OP_BGT, OP_BLT, OP_BEQ: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_src1    = 1'b1;
                ctrl.branch_code = (op4 == OP_BGT) ? BR_GT :
                                   (op4 == OP_BLT) ? BR_LT : BR_EQ;
            end
            OP_JMP: begin
                ctrl.jump      = 1'b1;
                ctrl.shift_src = 1'b1;
            end
            OP_HALT: begin
                // HALT retires as a nop: all control low.
            end
            default: begin
                is_illegal = 1'b1;
            end
        endcase
        if (upper_nz) begin
            ctrl       = '0;
            is_illegal = 1'b1;
        end
    end

    assign is_halt = (op4 == OP_HALT) && !upper_nz;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Registered control stage between IF/ID and ID/EX: decode, bubble insertion,
// sticky illegal flag, HALT drain FSM and a saturating bubble counter.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW          = 4,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned BCNT_W       = 16
) (
    input logic             clk,
    input logic             rst,
    ctrl_pipe_unit_if.slave bus
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ex_valid_q, ex_valid_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic              illegal_q, illegal_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  dec_halt;
    logic  accept;
    logic  issue;

    ctrl_decode #(
        .OPW (OPW)
    ) u_decode (
        .opcode     (bus.id_opcode),
        .ctrl       (dec_ctrl),
        .is_illegal (dec_illegal),
        .is_halt    (dec_halt)
    );

    // flush and stall both block acceptance; outside RUN the ID inputs are ignored.
    assign accept = bus.id_valid && !bus.stall && !bus.flush && (state_q == RUN);
    assign issue  = accept && !dec_illegal;

    // Next ID/EX contents, sticky illegal flag and bubble counting.
    always_comb begin
        ex_valid_d = issue;
        ex_ctrl_d  = issue ? dec_ctrl : '0;
        illegal_d  = illegal_q || (accept && dec_illegal);
        bcnt_d     = bcnt_q;
        if (!issue && (bcnt_q != '1)) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
        end
    end

    // HALT drain FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (issue && dec_halt) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = HALTED;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                // Absorbing until reset.
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            illegal_q  <= 1'b0;
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            illegal_q  <= illegal_d;
            bcnt_q     <= bcnt_d;
        end
    end

    // pc_hold and halted decode the registered state, so they are glitch-free.
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.pc_hold    = (state_q != RUN);
    assign bus.halted     = (state_q == HALTED);
    assign bus.illegal    = illegal_q;
    assign bus.bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: default instance plus a BCNT_W=2,
// DRAIN_CYCLES=0 instance for counter saturation and immediate halt.
module tb_ctrl_pipe_unit;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_bad    = 0;

    ctrl_pipe_unit_if #(.OPW(4), .BCNT_W(16)) bus_a ();
    ctrl_pipe_unit_if #(.OPW(4), .BCNT_W(2))  bus_b ();

    ctrl_pipe_unit #(
        .OPW          (4),
        .DRAIN_CYCLES (3),
        .BCNT_W       (16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    ctrl_pipe_unit #(
        .OPW          (4),
        .DRAIN_CYCLES (0),
        .BCNT_W       (2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [3:0] op, input logic st, input logic fl);
        bus_a.id_valid  = v;
        bus_a.id_opcode = op;
        bus_a.stall     = st;
        bus_a.flush     = fl;
    endtask

    // Hand-computed control vectors (bit 16 = reg_write ... bit 0 = shift_src).
    logic [3:0]  tbl_op   [9];
    logic [16:0] tbl_ctrl [9];

    initial begin
        tbl_op[0] = 4'h1; tbl_ctrl[0] = 17'h13C00;  // ANDI
        tbl_op[1] = 4'h2; tbl_ctrl[1] = 17'h15C00;  // ORI
        tbl_op[2] = 4'h7; tbl_ctrl[2] = 17'h00003;  // JMP
        tbl_op[3] = 4'hB; tbl_ctrl[3] = 17'h07060;  // SB
        tbl_op[4] = 4'h0; tbl_ctrl[4] = 17'h18000;  // ALU
        tbl_op[5] = 4'hA; tbl_ctrl[5] = 17'h17380;  // LBU
        tbl_op[6] = 4'hD; tbl_ctrl[6] = 17'h07040;  // SW
        tbl_op[7] = 4'h4; tbl_ctrl[7] = 17'h01014;  // BGT
        tbl_op[8] = 4'h6; tbl_ctrl[8] = 17'h01010;  // BEQ

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(1'b0, 4'h0, 1'b0, 1'b0);
        bus_b.id_valid  = 1'b0;
        bus_b.id_opcode = 4'h0;
        bus_b.stall     = 1'b0;
        bus_b.flush     = 1'b0;
        step();
        step();

        check_val("rst_ex_valid", 32'(bus_a.ex_valid), 32'd0);
        check_val("rst_ex_ctrl", 32'(bus_a.ex_ctrl), 32'd0);
        check_val("rst_pc_hold", 32'(bus_a.pc_hold), 32'd0);
        check_val("rst_halted", 32'(bus_a.halted), 32'd0);
        check_val("rst_illegal", 32'(bus_a.illegal), 32'd0);
        check_val("rst_bcnt", 32'(bus_a.bubble_cnt), 32'd0);

        // LW issues with one-cycle latency.
        rst_a = 1'b0;
        drive_a(1'b1, 4'hC, 1'b0, 1'b0);
        step();
        check_val("lw_valid", 32'(bus_a.ex_valid), 32'd1);
        check_val("lw_ctrl", 32'(bus_a.ex_ctrl), 32'h17300);
        check_val("lw_bcnt", 32'(bus_a.bubble_cnt), 32'd0);

        // BLT stalled two cycles, then issued.
        drive_a(1'b1, 4'h5, 1'b1, 1'b0);
        step();
        check_val("stall1_valid", 32'(bus_a.ex_valid), 32'd0);
        check_val("stall1_ctrl", 32'(bus_a.ex_ctrl), 32'd0);
        step();
        check_val("stall2_bcnt", 32'(bus_a.bubble_cnt), 32'd2);
        drive_a(1'b1, 4'h5, 1'b0, 1'b0);
        step();
        check_val("blt_valid", 32'(bus_a.ex_valid), 32'd1);
        check_val("blt_ctrl", 32'(bus_a.ex_ctrl), 32'h01018);
        check_val("blt_bcnt", 32'(bus_a.bubble_cnt), 32'd2);

        // Remaining legal opcodes back-to-back.
        for (int i = 0; i < 9; i++) begin
            drive_a(1'b1, tbl_op[i], 1'b0, 1'b0);
            step();
            check_val($sformatf("tbl%0d_valid", i), 32'(bus_a.ex_valid), 32'd1);
            check_val($sformatf("tbl%0d_ctrl", i), 32'(bus_a.ex_ctrl), 32'(tbl_ctrl[i]));
        end
        check_val("tbl_bcnt", 32'(bus_a.bubble_cnt), 32'd2);

        // No valid instruction -> bubble.
        drive_a(1'b0, 4'h0, 1'b0, 1'b0);
        step();
        check_val("idle_valid", 32'(bus_a.ex_valid), 32'd0);
        check_val("idle_bcnt", 32'(bus_a.bubble_cnt), 32'd3);

        // Flushed HALT is discarded.
        drive_a(1'b1, 4'hF, 1'b0, 1'b1);
        step();
        check_val("flush_halt_valid", 32'(bus_a.ex_valid), 32'd0);
        check_val("flush_halt_hold", 32'(bus_a.pc_hold), 32'd0);
        check_val("flush_halt_bcnt", 32'(bus_a.bubble_cnt), 32'd4);

        // flush + stall together count one bubble.
        drive_a(1'b1, 4'h0, 1'b1, 1'b1);
        step();
        check_val("flush_stall_bcnt", 32'(bus_a.bubble_cnt), 32'd5);

        // Illegal opcode: bubble plus sticky flag.
        drive_a(1'b1, 4'h8, 1'b0, 1'b0);
        step();
        check_val("ill_flag", 32'(bus_a.illegal), 32'd1);
        check_val("ill_valid", 32'(bus_a.ex_valid), 32'd0);
        check_val("ill_ctrl", 32'(bus_a.ex_ctrl), 32'd0);
        check_val("ill_bcnt", 32'(bus_a.bubble_cnt), 32'd6);
        drive_a(1'b1, 4'h0, 1'b0, 1'b0);
        step();
        check_val("post_ill_valid", 32'(bus_a.ex_valid), 32'd1);
        check_val("post_ill_ctrl", 32'(bus_a.ex_ctrl), 32'h18000);
        check_val("ill_sticky", 32'(bus_a.illegal), 32'd1);

        // Stalled HALT is not accepted.
        drive_a(1'b1, 4'hF, 1'b1, 1'b0);
        step();
        check_val("stall_halt_hold", 32'(bus_a.pc_hold), 32'd0);
        check_val("stall_halt_bcnt", 32'(bus_a.bubble_cnt), 32'd7);

        // HALT accepted: drain 3 cycles while ignoring ID.
        drive_a(1'b1, 4'hF, 1'b0, 1'b0);
        step();
        check_val("halt_valid", 32'(bus_a.ex_valid), 32'd1);
        check_val("halt_ctrl", 32'(bus_a.ex_ctrl), 32'd0);
        check_val("halt_hold", 32'(bus_a.pc_hold), 32'd1);
        check_val("halt_halted0", 32'(bus_a.halted), 32'd0);
        drive_a(1'b1, 4'h0, 1'b0, 1'b0);
        step();
        check_val("drain1_valid", 32'(bus_a.ex_valid), 32'd0);
        check_val("drain1_halted", 32'(bus_a.halted), 32'd0);
        step();
        check_val("drain2_halted", 32'(bus_a.halted), 32'd0);
        check_val("drain2_valid", 32'(bus_a.ex_valid), 32'd0);
        step();
        check_val("drain3_halted", 32'(bus_a.halted), 32'd1);
        check_val("drain3_hold", 32'(bus_a.pc_hold), 32'd1);
        check_val("drain3_bcnt", 32'(bus_a.bubble_cnt), 32'd10);
        step();
        check_val("halted_sticky", 32'(bus_a.halted), 32'd1);
        check_val("halted_valid", 32'(bus_a.ex_valid), 32'd0);
        check_val("halted_bcnt", 32'(bus_a.bubble_cnt), 32'd11);

        // Reset out of HALTED.
        rst_a = 1'b1;
        step();
        check_val("rst_halted_halted", 32'(bus_a.halted), 32'd0);
        check_val("rst_halted_hold", 32'(bus_a.pc_hold), 32'd0);
        check_val("rst_halted_ill", 32'(bus_a.illegal), 32'd0);

        // Reset in the middle of DRAIN.
        rst_a = 1'b0;
        drive_a(1'b1, 4'hF, 1'b0, 1'b0);
        step();
        check_val("halt2_hold", 32'(bus_a.pc_hold), 32'd1);
        drive_a(1'b1, 4'h0, 1'b0, 1'b0);
        step();
        rst_a = 1'b1;
        step();
        check_val("rst_drain_hold", 32'(bus_a.pc_hold), 32'd0);
        check_val("rst_drain_halted", 32'(bus_a.halted), 32'd0);
        check_val("rst_drain_bcnt", 32'(bus_a.bubble_cnt), 32'd0);
        check_val("rst_drain_valid", 32'(bus_a.ex_valid), 32'd0);
        rst_a = 1'b0;
        drive_a(1'b1, 4'hC, 1'b0, 1'b0);
        step();
        check_val("after_rst_valid", 32'(bus_a.ex_valid), 32'd1);
        check_val("after_rst_ctrl", 32'(bus_a.ex_ctrl), 32'h17300);

        // Narrow counter saturates; zero drain halts immediately.
        rst_b = 1'b0;
        step();
        step();
        step();
        check_val("sat3_bcnt", 32'(bus_b.bubble_cnt), 32'd3);
        step();
        step();
        check_val("sat5_bcnt", 32'(bus_b.bubble_cnt), 32'd3);
        bus_b.id_valid  = 1'b1;
        bus_b.id_opcode = 4'hF;
        step();
        check_val("d0_halted", 32'(bus_b.halted), 32'd1);
        check_val("d0_hold", 32'(bus_b.pc_hold), 32'd1);
        check_val("d0_valid", 32'(bus_b.ex_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Registered, pipelined successor to the combinational opcode decoder.
- Decodes the ID-stage opcode into the control bundle and registers it into the ID/EX stage.
- Inserts bubbles on stall or flush, detects illegal opcodes, and runs a HALT drain FSM that freezes fetch and retires in-flight instructions before asserting halted.
- Also keeps a saturating bubble counter for performance debug.
- Sits between the IF/ID register and the ID/EX register of the CPU pipeline.

Parameters:
- OPW, 4, opcode width; decode uses opcode[3:0]; upper bits must be 0, else illegal.
- DRAIN_CYCLES, 3, cycles after HALT acceptance before halted rises (EX, MEM, WB retire).
- BCNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  OPW  opcode of the ID instruction.
- stall  in  1  hazard unit load-use stall; ID holds, EX gets a bubble.
- flush  in  1  branch-taken or jump redirect; ID instruction is squashed.
- ex_valid  out  1  ID/EX register holds a real instruction.
- ex_ctrl  out  CTRL_W  registered control bundle; field order is fixed in the package.
- pc_hold  out  1  freeze PC and IF/ID (high in DRAIN and HALTED).
- halted  out  1  processor halted; sticky until rst.
- illegal  out  1  sticky: an illegal opcode was accepted.
- bubble_cnt  out  BCNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset values: ex_valid=0, ex_ctrl=0, pc_hold=0, halted=0, illegal=0, bubble_cnt=0, FSM=RUN, drain counter=0.
- accept = id_valid & !stall & !flush & (state==RUN).
- Latency: one cycle. Opcode accepted at edge N appears on ex_ctrl/ex_valid after edge N+1.
- Decode table. Fields not listed are 0; don't-cares are driven 0 in this generation.
  - 0000 ALU A-type: regWrite, R15write, ALUop=00.
  - 0001 ANDI: regWrite, ALUop=01, ALUsrc1, ALUsrc2, extSrc.
  - 0010 ORI: as ANDI, ALUop=10.
  - 1010 LBU: regWrite, ALUop=11, ALUsrc1, memRead, MemtoReg, loadByte.
  - 1011 SB: ALUop=11, ALUsrc1, memWrite, sByte.
  - 1100 LW: regWrite, ALUop=11, ALUsrc1, memRead, MemtoReg.
  - 1101 SW: ALUop=11, ALUsrc1, memWrite.
  - 0100 BGT: branch, branchCode=01, ALUsrc1.
  - 0101 BLT: branch, branchCode=10, ALUsrc1.
  - 0110 BEQ: branch, branchCode=00, ALUsrc1.
  - 0111 JMP: jump, shift_Src.
  - 1111 HALT: all control 0; ex_valid=1, so HALT retires as a nop.
- Any other opcode, or nonzero upper bits: illegal. ex_valid=0, ex_ctrl=0, illegal<=1 (sticky). Counts as a bubble.
- Bubble condition: any cycle where ex_valid is loaded 0, i.e. stall, flush, !id_valid, illegal, or not in RUN. Result: ex_ctrl=0. bubble_cnt increments by 1 and saturates at all-ones.
- Priority, highest first: rst > flush > stall > decode. flush and stall in the same cycle: bubble, counted once.
- FSM:
  - RUN: accepted HALT -> DRAIN, counter<=DRAIN_CYCLES, pc_hold<=1.
  - DRAIN: counter decrements each cycle. When counter==1 -> HALTED, halted<=1, counter<=0. stall, flush and id inputs are ignored; bubbles are issued.
  - HALTED: absorbing until rst. pc_hold=1, halted=1, bubbles are issued.
  - DRAIN_CYCLES=0: RUN -> HALTED directly on HALT acceptance.
- HALT with stall or flush in the same cycle: not accepted. Flushed HALT is discarded; stalled HALT is re-presented.
- rst mid-DRAIN or in HALTED returns every output to its reset value on the next edge.

Decomposition:
- Package ctrl_pkg:
  - opcode localparams (OP_ALU, OP_ANDI, OP_ORI, OP_LBU, OP_SB, OP_LW, OP_SW, OP_BGT, OP_BLT, OP_BEQ, OP_JMP, OP_HALT);
  - ALUop and branchCode encodings;
  - packed struct ctrl_t with fields in decode-table order, and CTRL_W=$bits(ctrl_t);
  - FSM state enum {RUN, DRAIN, HALTED}.
- Sub-module ctrl_decode: purely combinational opcode -> ctrl_t plus an is_illegal flag.
- Top module: pipeline register, FSM, counters.

Test Plan:
- Reset, then opcode 1100 with id_valid=1 -> next cycle ex_valid=1, ex_ctrl has regWrite=1, ALUop=11, ALUsrc1=1, memRead=1, MemtoReg=1, all else 0.
- Opcode 0101 with stall=1 for 2 cycles, then stall=0 -> two bubbles, bubble_cnt=2, then BLT with branchCode=10.
- Opcode 1111 accepted, DRAIN_CYCLES=3 -> pc_hold=1 from the next cycle, halted=1 exactly 3 cycles later; an opcode 0000 presented meanwhile is not issued.
- Opcode 1111 with flush=1 -> no FSM change, bubble issued; opcode 1000 next -> illegal=1 stays high, ex_valid=0.
- rst asserted during DRAIN -> next cycle state RUN, pc_hold=0, halted=0, bubble_cnt=0.
- BCNT_W=2 with 5 consecutive bubbles -> bubble_cnt saturates at 3.
